stopwatch_lap: RTL

Parametrised successor to the StopWatch block: a BCD stopwatch (mm:ss.cc, 1/100 s resolution) with run/pause/clear control, a circular lap-time buffer and an overflow flag. Operator buttons fStart, fStop and fLap are active-low asynchronous inputs, synchronised internally. The block sits between the board button inputs and the 7-segment display driver and the lap read-out logic.

---
 rtl/stopwatch_lap.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_lap.sv
// BCD stopwatch (mm:ss.cc) with run/pause/clear control, circular lap buffer and sticky overflow.
// Optional press debouncer enabled by defining STOPWATCH_DEBOUNCE_EN.
module stopwatch_lap #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int LAP_DEPTH    = 8,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           fStart,
    input  logic                           fStop,
    input  logic                           fLap,
    input  logic [$clog2(LAP_DEPTH)-1:0]   iLapIdx,
    output logic [23:0]                    oTime,
    output logic                           oRun,
    output logic [1:0]                     oState,
    output logic                           oOvf,
    output logic [$clog2(LAP_DEPTH+1)-1:0] oLapCnt,
    output logic [23:0]                    oLapTime
);
    localparam int DIV = CLK_HZ / 100;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(LAP_DEPTH);
    localparam int CW  = $clog2(LAP_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    // Button channels are packed {lap, stop, start}; idle level is high.
    logic [2:0] w_btn;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_prev;
    logic [2:0] w_level;
    logic [2:0] w_press;
    logic       w_start;
    logic       w_stop;
    logic       w_lap;

    assign w_btn = {fLap, fStop, fStart};

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
            r_prev  <= 3'b111;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int DCW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [2:0]     r_deb;
    logic [DCW-1:0] r_dcnt [3];

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_deb <= 3'b111;
            for (int i = 0; i < 3; i++) r_dcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DCW'(DEBOUNCE_CYC - 1)) begin
                    r_deb[i]  <= r_sync2[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_level = r_deb;
`else
    // Keeps the debounce parameter referenced when the debouncer is compiled out.
    logic [31:0] w_unused_db;
    assign w_unused_db = DEBOUNCE_CYC;
    assign w_level     = r_sync2;
`endif

    assign w_press = r_prev & ~w_level;
    assign w_start = w_press[0];
    assign w_stop  = w_press[1];
    assign w_lap   = w_press[2];

    state_t r_state;
    state_t w_next;
    logic   w_clear;

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_RUN;
            S_RUN:   if (w_stop || w_start) w_next = S_PAUSE;
            S_PAUSE: begin
                if (w_stop) begin
                    w_next  = S_IDLE;
                    w_clear = 1'b1;
                end else if (w_start) begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    logic [PW-1:0] r_presc;
    logic [23:0]   r_time;
    logic          r_ovf;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_lap_cnt;
    logic [23:0]   r_lap_time;
    logic [23:0]   r_lap_ram [LAP_DEPTH];
    logic          w_tick;
    logic [23:0]   w_time_inc;
    logic          w_carry;
    logic [AW-1:0] w_slot;

    assign w_tick = (r_state == S_RUN) && (r_presc == PW'(DIV - 1));
    assign w_slot = r_wr_ptr - AW'(1) - iLapIdx;

    // Ripple BCD increment, c1 first; tens-of-seconds and tens-of-minutes wrap at 5.
    always_comb begin
        w_time_inc = r_time;
        w_carry    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (w_carry) begin
                if (r_time[4*i +: 4] == ((i == 3 || i == 5) ? 4'd5 : 4'd9)) begin
                    w_time_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_time_inc[4*i +: 4] = r_time[4*i +: 4] + 4'd1;
                    w_carry              = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_time     <= '0;
            r_ovf      <= 1'b0;
            r_wr_ptr   <= '0;
            r_lap_cnt  <= '0;
            r_lap_time <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_presc   <= '0;
                r_time    <= '0;
                r_ovf     <= 1'b0;
                r_wr_ptr  <= '0;
                r_lap_cnt <= '0;
            end else if (r_state == S_RUN) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_time  <= w_time_inc;
                    if (w_carry) r_ovf <= 1'b1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
                if (w_lap) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (r_lap_cnt != CW'(LAP_DEPTH)) r_lap_cnt <= r_lap_cnt + 1'b1;
                end
            end
            r_lap_time <= (CW'(iLapIdx) < r_lap_cnt) ? r_lap_ram[w_slot] : 24'd0;
        end
    end

    // Lap storage holds the pre-tick time of the capture cycle.
    always_ff @(posedge Clk) begin
        if (r_state == S_RUN && w_lap) r_lap_ram[r_wr_ptr] <= r_time;
    end

    assign oTime    = r_time;
    assign oRun     = (r_state == S_RUN);
    assign oState   = r_state;
    assign oOvf     = r_ovf;
    assign oLapCnt  = r_lap_cnt;
    assign oLapTime = r_lap_time;
endmodule
